// File: rtl/fetch_if.sv
// IF-stage bundle between fetch_stage, the hazard unit, EX redirect and instruction memory.
// With FETCH_PERF_CNT_EN defined the bundle also carries the fetch/stall performance counters.
interface fetch_if;
  // Control contract: flush outranks stall on every edge. stall freezes the PC and IF/ID.
  // The memory answers inst for inst_addr within the same cycle.
  logic        stall;
  logic        flush;
  logic [63:0] branch_target;
  logic [63:0] inst_addr;
  logic [31:0] inst;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_inst;
  logic        ifid_valid;
  logic        halted;
  logic [1:0]  dbg_state;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
  logic [31:0] stall_count;

  modport master (
    input  stall, flush, branch_target, inst,
    output inst_addr, ifid_pc, ifid_inst, ifid_valid, halted, dbg_state,
           fetch_count, stall_count
  );
  modport slave (
    output stall, flush, branch_target, inst,
    input  inst_addr, ifid_pc, ifid_inst, ifid_valid, halted, dbg_state,
           fetch_count, stall_count
  );
`else
  modport master (
    input  stall, flush, branch_target, inst,
    output inst_addr, ifid_pc, ifid_inst, ifid_valid, halted, dbg_state
  );
  modport slave (
    output stall, flush, branch_target, inst,
    input  inst_addr, ifid_pc, ifid_inst, ifid_valid, halted, dbg_state
  );
`endif
endinterface

// File: rtl/fetch_stage.sv
// RV64 IF stage: owns the PC, fetches from combinational IMEM, fills IF/ID, handles stall/flush/halt.
// Optional saturating fetch/stall counters are enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 672,
  parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
  input  logic    clk,
  input  logic    reset,
  fetch_if.master bus
);
  typedef enum logic [1:0] {ST_BOOT = 2'd0, ST_FETCH = 2'd1, ST_HALTED = 2'd2} state_e;

  localparam logic [63:0] LAST_ADDR = 64'(IMEM_BYTES) - 64'd4;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [63:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_inst_q, ifid_inst_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        halted_q, halted_d;
  logic        in_range;
  logic        capture;
  logic        stall_hit;

  assign in_range = (pc_q <= LAST_ADDR);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_inst_d  = ifid_inst_q;
    ifid_valid_d = ifid_valid_q;
    halted_d     = halted_q;
    capture      = 1'b0;
    stall_hit    = 1'b0;
    case (state_q)
      ST_BOOT: state_d = ST_FETCH;
      default: begin
        if (bus.flush) begin
          pc_d         = {bus.branch_target[63:2], 2'b00};
          ifid_pc_d    = 64'h0;
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
          state_d      = ST_FETCH;
          halted_d     = 1'b0;
        end else if (bus.stall) begin
          stall_hit = (state_q == ST_FETCH);
        end else if (state_q == ST_FETCH && in_range) begin
          capture      = 1'b1;
          ifid_pc_d    = pc_q;
          ifid_inst_d  = bus.inst;
          ifid_valid_d = 1'b1;
          pc_d         = pc_q + 64'd4;
        end else begin
          // Ran off the end of memory (or already halted): park with a bubble.
          ifid_pc_d    = 64'h0;
          ifid_inst_d  = NOP_INST;
          ifid_valid_d = 1'b0;
          state_d      = ST_HALTED;
          halted_d     = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_PC;
      ifid_pc_q    <= 64'h0;
      ifid_inst_q  <= NOP_INST;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_inst_q  <= ifid_inst_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
    end
  end

  assign bus.inst_addr  = pc_q;
  assign bus.ifid_pc    = ifid_pc_q;
  assign bus.ifid_inst  = ifid_inst_q;
  assign bus.ifid_valid = ifid_valid_q;
  assign bus.halted     = halted_q;
  assign bus.dbg_state  = state_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (capture && fetch_cnt_q != 32'hFFFF_FFFF) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (stall_hit && stall_cnt_q != 32'hFFFF_FFFF) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.fetch_count = fetch_cnt_q;
  assign bus.stall_count = stall_cnt_q;

  logic unused_ok;
  assign unused_ok = ^bus.branch_target[1:0];
`else
  logic unused_ok;
  assign unused_ok = ^{bus.branch_target[1:0], capture, stall_hit};
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed test-plan sequences with literal expectations, then random
// stall/flush traffic checked every cycle against a behavioural model of the fetch rules.
module tb_fetch_stage;
  localparam int          IMEM_BYTES = 672;
  localparam int          MEM_WORDS  = IMEM_BYTES / 4;
  localparam logic [31:0] NOP        = 32'h0000_0013;
  localparam logic [63:0] LAST       = 64'd668;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_if bus ();

  fetch_stage #(
    .RESET_PC  (64'h0),
    .IMEM_BYTES(IMEM_BYTES),
    .NOP_INST  (NOP)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  // Instruction memory; out-of-range reads return junk the DUT must ignore.
  logic [31:0] mem [MEM_WORDS];
  assign bus.inst = (bus.inst_addr <= LAST) ? mem[bus.inst_addr[9:2]] : 32'hDEAD_BEEF;

  int n_total = 0;
  int n_pass  = 0;

  // Behavioural model of the stage.
  logic [63:0] m_pc;
  logic        m_boot;
  logic        m_halted;
  logic [63:0] m_ifid_pc;
  logic [31:0] m_ifid_inst;
  logic        m_ifid_valid;
  logic [31:0] m_fetch_cnt;
  logic [31:0] m_stall_cnt;
  logic [63:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pc = 64'h0; m_boot = 1'b1; m_halted = 1'b0;
    m_ifid_pc = 64'h0; m_ifid_inst = NOP; m_ifid_valid = 1'b0;
    m_fetch_cnt = 32'h0; m_stall_cnt = 32'h0;
  endtask

  task automatic model_bubble();
    m_ifid_pc = 64'h0; m_ifid_inst = NOP; m_ifid_valid = 1'b0;
  endtask

  task automatic model_step();
    if (m_boot) begin
      m_boot = 1'b0;
    end else if (bus.flush) begin
      m_pc = bus.branch_target & ~64'h3;
      model_bubble();
      m_halted = 1'b0;
    end else if (bus.stall) begin
      if (!m_halted && m_stall_cnt != 32'hFFFF_FFFF) m_stall_cnt++;
    end else if (!m_halted && m_pc <= LAST) begin
      m_ifid_pc = m_pc;
      m_ifid_inst = mem[int'(m_pc / 4)];
      m_ifid_valid = 1'b1;
      m_pc = m_pc + 64'd4;
      if (m_fetch_cnt != 32'hFFFF_FFFF) m_fetch_cnt++;
    end else begin
      model_bubble();
      m_halted = 1'b1;
    end
  endtask

  task automatic compare_model();
    check("inst_addr", bus.inst_addr, m_pc);
    check("ifid_valid", 64'(bus.ifid_valid), 64'(m_ifid_valid));
    check("ifid_inst", 64'(bus.ifid_inst), 64'(m_ifid_inst));
    if (m_ifid_valid) check("ifid_pc", bus.ifid_pc, m_ifid_pc);
    check("halted", 64'(bus.halted), 64'(m_halted));
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", 64'(bus.fetch_count), 64'(m_fetch_cnt));
    check("stall_count", 64'(bus.stall_count), 64'(m_stall_cnt));
`endif
  endtask

  // One clock: model steps on the rising edge, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  task automatic drive(input logic st, input logic fl, input logic [63:0] tgt);
    bus.stall = st; bus.flush = fl; bus.branch_target = tgt;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_inst_addr"}, bus.inst_addr, 64'h0);
    check({tag, "_ifid_pc"}, bus.ifid_pc, 64'h0);
    check({tag, "_ifid_inst"}, 64'(bus.ifid_inst), 64'h13);
    check({tag, "_ifid_valid"}, 64'(bus.ifid_valid), 64'h0);
    check({tag, "_halted"}, 64'(bus.halted), 64'h0);
  endtask

  initial begin
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = $urandom;
    drive(1'b0, 1'b0, 64'h0);
    rst_n = 1'b0;
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Boot edge: no capture, then sequential fetch from 0.
    tick();
    check("boot_valid", 64'(bus.ifid_valid), 64'h0);
    check("boot_pc", bus.inst_addr, 64'h0);
    for (int a = 0; a < 3; a++) exp_q.push_back(64'(a * 4));
    while (exp_q.size() > 0) begin
      logic [63:0] e;
      e = exp_q.pop_front();
      tick();
      check("seq_ifid_pc", bus.ifid_pc, e);
      check("seq_ifid_inst", 64'(bus.ifid_inst), 64'(mem[int'(e / 4)]));
      check("seq_valid", 64'(bus.ifid_valid), 64'h1);
    end
    tick();

    // Stall three cycles at pc=0x10.
    drive(1'b1, 1'b0, 64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc", bus.inst_addr, 64'h10);
      check("stall_ifid_pc", bus.ifid_pc, 64'h0C);
    end
    drive(1'b0, 1'b0, 64'h0);
    tick();
    check("unstall_ifid_pc", bus.ifid_pc, 64'h10);

    // Redirect to 0x268, then flush to 0x190 from there.
    drive(1'b0, 1'b1, 64'h268);
    tick();
    check("redir_pc", bus.inst_addr, 64'h268);
    drive(1'b0, 1'b1, 64'h190);
    tick();
    check("flush_valid", 64'(bus.ifid_valid), 64'h0);
    check("flush_pc", bus.inst_addr, 64'h190);
    drive(1'b0, 1'b0, 64'h0);
    tick();
    check("target_ifid_pc", bus.ifid_pc, 64'h190);
    check("target_valid", 64'(bus.ifid_valid), 64'h1);

    // Flush and stall together; misaligned target.
    drive(1'b1, 1'b1, 64'h1F3);
    tick();
    check("fs_pc", bus.inst_addr, 64'h1F0);
    check("fs_valid", 64'(bus.ifid_valid), 64'h0);
    check("fs_inst", 64'(bus.ifid_inst), 64'h13);

    // Run off the end of memory, then recover with a flush to 0.
    drive(1'b0, 1'b1, 64'h290);
    tick();
    drive(1'b0, 1'b0, 64'h0);
    for (int i = 0; i < 4; i++) tick();
    check("last_ifid_pc", bus.ifid_pc, 64'h29C);
    check("end_pc", bus.inst_addr, 64'h2A0);
    tick();
    check("halt_flag", 64'(bus.halted), 64'h1);
    check("halt_valid", 64'(bus.ifid_valid), 64'h0);
    tick();
    check("halt_hold_pc", bus.inst_addr, 64'h2A0);
    drive(1'b0, 1'b1, 64'h0);
    tick();
    check("resume_halted", 64'(bus.halted), 64'h0);
    drive(1'b0, 1'b0, 64'h0);
    tick();
    check("resume_ifid_pc", bus.ifid_pc, 64'h0);
    check("resume_valid", 64'(bus.ifid_valid), 64'h1);

    // Asynchronous reset mid-cycle with pc=0x80.
    drive(1'b0, 1'b1, 64'h80);
    tick();
    drive(1'b0, 1'b0, 64'h0);
    check("pre_areset_pc", bus.inst_addr, 64'h80);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_reset_values("areset");
    @(negedge clk);
    rst_n = 1'b1;

    // Five fetches then two stall cycles.
    tick();
    for (int i = 0; i < 5; i++) tick();
    drive(1'b1, 1'b0, 64'h0);
    tick();
    tick();
    drive(1'b0, 1'b0, 64'h0);
`ifdef FETCH_PERF_CNT_EN
    check("perf_fetch", 64'(bus.fetch_count), 64'd5);
    check("perf_stall", 64'(bus.stall_count), 64'd2);
`endif
    check("perf_pc", bus.inst_addr, 64'h14);

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      logic [63:0] tgt;
      if ($urandom_range(0, 3) != 0) tgt = 64'($urandom_range(0, 700));
      else tgt = {$urandom, $urandom};
      drive(logic'($urandom_range(0, 99) < 20), logic'($urandom_range(0, 99) < 6), tgt);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
